exc_req_unit: RTL

//  Source side of the CP0 trap interface. Collects synchronous trap requests from the decode/control
//  FSM, external interrupt lines and an internal count/compare timer. Prioritises them and, at

---
 rtl/exc_req_unit_if.sv | 23 ++
 rtl/exc_req_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/exc_req_unit_if.sv
// Trap handshake between the multi-cycle controller (requests) and the exception
// request unit, which drives the one-cycle CP0 exception/eret pulses back out.
interface exc_req_unit_if;
    logic       insn_boundary;
    logic       syscall_req;
    logic       break_req;
    logic       teq_req;
    logic       eret_req;
    logic       exception;
    logic [4:0] cause;
    logic       eret;
    logic       trap_busy;

    modport master (
        output insn_boundary, syscall_req, break_req, teq_req, eret_req,
        input  exception, cause, eret, trap_busy
    );

    modport slave (
        input  insn_boundary, syscall_req, break_req, teq_req, eret_req,
        output exception, cause, eret, trap_busy
    );
endinterface

// File: rtl/exc_req_unit.sv
// Source side of the CP0 trap interface: latches sync trap requests, synchronises irqs,
// runs the count/compare timer and sequences prioritised exception/eret pulses.
module exc_req_unit #(
    parameter int unsigned NUM_IRQ = 4,
    parameter int unsigned TIMER_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    exc_req_unit_if.slave      trap,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [31:0]        status,
    input  logic               tmr_we,
    input  logic               tmr_sel,
    input  logic [31:0]        tmr_wdata,
    output logic               timer_int,
    output logic [31:0]        tmr_rdata,
    output logic               irq_pending
);

    localparam logic [4:0] CAUSE_INT = 5'd0;
    localparam logic [4:0] CAUSE_SYS = 5'd8;
    localparam logic [4:0] CAUSE_BRK = 5'd9;
    localparam logic [4:0] CAUSE_TEQ = 5'd13;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_ERETS,
        S_WAIT
    } state_t;

    state_t state, state_nxt;
    logic [4:0] cause_q, cause_nxt, win_cause;

    logic [NUM_IRQ-1:0] irq_s1, irq_s2;
    logic pend_sys, pend_brk, pend_teq, pend_eret;
    logic sync_pend, irq_cand;
    logic clr_sys, clr_brk, clr_teq, clr_eret;

    logic [TIMER_W-1:0] count, compare;
    logic cnt_wr, cmp_wr, tmr_match;
    logic unused_bits;

    assign unused_bits = ^{status[31:1], tmr_wdata};

    // Two-flop synchroniser per interrupt line; levels are not latched.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_s1 <= '0;
            irq_s2 <= '0;
        end else begin
            irq_s1 <= irq_in;
            irq_s2 <= irq_s1;
        end
    end

    assign irq_pending = (|irq_s2) | timer_int;
    assign sync_pend   = pend_teq | pend_brk | pend_sys;
    assign irq_cand    = status[0] & ~sync_pend & ~pend_eret & irq_pending;

    // A flag is dropped only in the cycle its own pulse is on the wire; a fresh
    // request arriving in that same cycle keeps it pending.
    assign clr_teq  = (state == S_ISSUE) && (cause_q == CAUSE_TEQ);
    assign clr_brk  = (state == S_ISSUE) && (cause_q == CAUSE_BRK);
    assign clr_sys  = (state == S_ISSUE) && (cause_q == CAUSE_SYS);
    assign clr_eret = (state == S_ERETS);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_sys  <= 1'b0;
            pend_brk  <= 1'b0;
            pend_teq  <= 1'b0;
            pend_eret <= 1'b0;
        end else begin
            pend_sys  <= trap.syscall_req | (pend_sys  & ~clr_sys);
            pend_brk  <= trap.break_req   | (pend_brk  & ~clr_brk);
            pend_teq  <= trap.teq_req     | (pend_teq  & ~clr_teq);
            pend_eret <= trap.eret_req    | (pend_eret & ~clr_eret);
        end
    end

    always_comb begin
        win_cause = CAUSE_INT;
        if (pend_teq)      win_cause = CAUSE_TEQ;
        else if (pend_brk) win_cause = CAUSE_BRK;
        else if (pend_sys) win_cause = CAUSE_SYS;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            cause_q <= CAUSE_INT;
        end else begin
            state   <= state_nxt;
            cause_q <= cause_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = cause_q;
        case (state)
            S_IDLE: begin
                if (trap.insn_boundary) begin
                    if (sync_pend || irq_cand) begin
                        state_nxt = S_ISSUE;
                        cause_nxt = win_cause;
                    end else if (pend_eret) begin
                        state_nxt = S_ERETS;
                    end
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_ERETS: state_nxt = S_WAIT;
            S_WAIT:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign trap.exception = (state == S_ISSUE);
    assign trap.cause     = (state == S_ISSUE) ? cause_q : CAUSE_INT;
    assign trap.eret      = (state == S_ERETS);
    assign trap.trap_busy = (state != S_IDLE);

    assign cnt_wr    = tmr_we & ~tmr_sel;
    assign cmp_wr    = tmr_we &  tmr_sel;
    assign tmr_match = (compare != '0) && (count == compare);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count     <= '0;
            compare   <= '0;
            timer_int <= 1'b0;
        end else begin
            count <= cnt_wr ? tmr_wdata[TIMER_W-1:0] : count + TIMER_W'(1);
            if (cmp_wr) begin
                compare   <= tmr_wdata[TIMER_W-1:0];
                timer_int <= 1'b0;
            end else if (tmr_match) begin
                timer_int <= 1'b1;
            end
        end
    end

    always_comb begin
        tmr_rdata = '0;
        tmr_rdata[TIMER_W-1:0] = tmr_sel ? compare : count;
    end

endmodule
